// File: rtl/alu_write_arb_pkg.sv
// Shared types and default sizes for the ALU data-memory write arbiter.
// REG_WIDTH falls back to the ALU register width when no ALU header was seen first.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

package alu_write_arb_pkg;

  localparam int unsigned NUM_CORES_DEF      = 4;
  localparam int unsigned MEM_ADDR_WIDTH_DEF = 16;
  localparam int unsigned FIFO_DEPTH_DEF     = 2;
  localparam int unsigned REG_W              = `REG_WIDTH;

  // One queued write request as carried through a core FIFO (address in the upper bits).
  typedef struct packed {
    logic [MEM_ADDR_WIDTH_DEF-1:0] addr;
    logic [REG_W-1:0]              data;
  } mem_write_req_s;

endpackage

// File: rtl/alu_write_fifo.sv
// Purpose: small per-core request FIFO, power-of-two depth, synchronous reset.
// Latency: a pushed entry is visible on dout_o the cycle after the push edge.
// Backpressure: caller must not push when full_o or pop when empty_o.
module alu_write_fifo #(
  parameter int unsigned depth = 2,
  parameter int unsigned width = 48
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [width-1:0]         din_i,
  output logic [width-1:0]         dout_o,
  output logic [$clog2(depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned ptr_w = $clog2(depth);
  localparam int unsigned cnt_w = ptr_w + 1;

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic [cnt_w-1:0] count;

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem[wr_ptr] <= din_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; push+pop leaves count unchanged.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + ptr_w'(1);
      if (pop_i)  rd_ptr <= rd_ptr + ptr_w'(1);
      case ({push_i, pop_i})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout_o  = mem[rd_ptr];
  assign count_o = count;
  assign full_o  = (count == cnt_w'(depth));
  assign empty_o = (count == '0);

  a_no_push_full: assert property (@(posedge clk_i) disable iff (reset_i) !(push_i && full_o));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (reset_i) !(pop_i && empty_o));

endmodule

// File: rtl/alu_write_arb.sv
// Purpose: round-robin merge of per-core write requests onto one registered memory write port.
// Latency: request accepted at edge E0 appears on mem_valid_o after edge E1; one beat/cycle sustained.
// Backpressure: mem_ready_i low freezes the output beat; full core FIFOs drop req_ready_o.
module alu_write_arb
  import alu_write_arb_pkg::*;
#(
  parameter int unsigned num_cores      = NUM_CORES_DEF,
  parameter int unsigned mem_addr_width = MEM_ADDR_WIDTH_DEF,
  parameter int unsigned fifo_depth     = FIFO_DEPTH_DEF
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [num_cores-1:0]                     req_valid_i,
  input  logic [num_cores-1:0][mem_addr_width-1:0] req_addr_i,
  input  logic [num_cores-1:0][`REG_WIDTH-1:0]     req_data_i,
  output logic [num_cores-1:0]                     req_ready_o,
  output logic                                     mem_valid_o,
  output logic [mem_addr_width-1:0]                mem_addr_o,
  output logic [`REG_WIDTH-1:0]                    mem_data_o,
  output logic [$clog2(num_cores)-1:0]             mem_src_o,
  input  logic                                     mem_ready_i,
  output logic                                     busy_o
);

  localparam int unsigned src_width   = $clog2(num_cores);
  localparam int unsigned cnt_width   = $clog2(fifo_depth) + 1;
  localparam int unsigned entry_width = mem_addr_width + `REG_WIDTH;

  logic [num_cores-1:0]   push;
  logic [num_cores-1:0]   pop;
  logic [num_cores-1:0]   full;
  logic [num_cores-1:0]   empty;
  logic [cnt_width-1:0]   count [num_cores];
  logic [entry_width-1:0] head  [num_cores];

  logic                   load_en;
  logic                   pick_vld;
  logic [src_width-1:0]   pick_idx;
  logic [entry_width-1:0] head_sel;
  logic                   any_queued;

  logic                      mem_valid_q;
  logic [mem_addr_width-1:0] mem_addr_q;
  logic [`REG_WIDTH-1:0]     mem_data_q;
  logic [src_width-1:0]      mem_src_q;
  logic [src_width-1:0]      last_grant;

  // First requester after 'last' in circular order: rotate a doubled copy so the
  // scan starts at last+1, then map the winning offset back to a core index.
  function automatic logic [src_width:0] rr_pick(input logic [num_cores-1:0] cand,
                                                 input logic [src_width-1:0] last);
    logic [2*num_cores-1:0] dbl;
    logic [src_width:0]     base;
    logic [num_cores-1:0]   rot;
    logic [src_width:0]     res;
    int                     g;
    dbl  = {cand, cand};
    base = {1'b0, last} + {{src_width{1'b0}}, 1'b1};
    rot  = num_cores'(dbl >> base);
    res  = '0;
    g    = 0;
    for (int k = num_cores - 1; k >= 0; k--) begin
      if (rot[k]) begin
        g = int'(base) + k;
        if (g >= int'(num_cores)) g = g - int'(num_cores);
        res = {1'b1, src_width'(g)};
      end
    end
    return res;
  endfunction

  for (genvar i = 0; i < num_cores; i++) begin : g_core
    alu_write_fifo #(
      .depth(fifo_depth),
      .width(entry_width)
    ) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .din_i   ({req_addr_i[i], req_data_i[i]}),
      .dout_o  (head[i]),
      .count_o (count[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
    // Ready comes from registered occupancy only, so a full FIFO being popped
    // this cycle still refuses a push until the next cycle.
    assign req_ready_o[i] = ~full[i];
    assign push[i]        = req_valid_i[i] & ~full[i];
    assign pop[i]         = load_en & pick_vld & (pick_idx == src_width'(i));
  end

  assign load_en = ~mem_valid_q | mem_ready_i;

  // Pick the next core among FIFOs that were non-empty at the start of the cycle.
  always_comb begin
    {pick_vld, pick_idx} = rr_pick(~empty, last_grant);
  end

  // Select the head entry of the granted core.
  always_comb begin
    head_sel = '0;
    for (int i = 0; i < num_cores; i++) begin
      if (pick_idx == src_width'(i)) head_sel = head[i];
    end
  end

  // Output beat register: reload when empty or accepted, otherwise hold the stalled beat.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_src_q   <= '0;
      last_grant  <= src_width'(num_cores - 1);
    end else if (load_en) begin
      if (pick_vld) begin
        mem_valid_q              <= 1'b1;
        {mem_addr_q, mem_data_q} <= head_sel;
        mem_src_q                <= pick_idx;
        last_grant               <= pick_idx;
      end else begin
        mem_valid_q <= 1'b0;
      end
    end
  end

  // Any queued entry keeps the block busy.
  always_comb begin
    any_queued = 1'b0;
    for (int i = 0; i < num_cores; i++) begin
      if (count[i] != '0) any_queued = 1'b1;
    end
  end

  assign mem_valid_o = mem_valid_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign mem_src_o   = mem_src_q;
  assign busy_o      = mem_valid_q | any_queued;

  a_mem_stable: assert property (@(posedge clk_i) disable iff (reset_i)
    (mem_valid_o && !mem_ready_i) |=>
      (mem_valid_o && $stable(mem_addr_o) && $stable(mem_data_o) && $stable(mem_src_o)));

endmodule

// File: tb/tb_alu_write_arb.sv
// Self-checking bench for alu_write_arb: per-scenario tasks plus a scoreboard of
// accepted requests that every emitted memory beat is matched against.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module tb_alu_write_arb;
  import alu_write_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = `REG_WIDTH;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic [N-1:0]        req_valid_i;
  logic [N-1:0][AW-1:0] req_addr_i;
  logic [N-1:0][DW-1:0] req_data_i;
  logic [N-1:0]        req_ready_o;
  logic                mem_valid_o;
  logic [AW-1:0]       mem_addr_o;
  logic [DW-1:0]       mem_data_o;
  logic [1:0]          mem_src_o;
  logic                mem_ready_i;
  logic                busy_o;

  typedef struct packed {
    logic [1:0]     src;
    mem_write_req_s req;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  sb_entry_t mon_e;
  int        mon_idx;
  int        total = 0;
  int        bad   = 0;

  alu_write_arb #(
    .num_cores(N),
    .mem_addr_width(AW),
    .fifo_depth(2)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .mem_valid_o (mem_valid_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_src_o   (mem_src_o),
    .mem_ready_i (mem_ready_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Scoreboard: on the falling edge, inputs/outputs show what the next rising edge will do.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (mem_valid_o && mem_ready_i) begin
        mon_idx = -1;
        for (int k = 0; k < sb_q.size(); k++)
          if (mon_idx < 0 && sb_q[k].src == mem_src_o) mon_idx = k;
        total++;
        if (mon_idx < 0) begin
          bad++;
          $display("FAIL sb_unexpected: beat src=%0d addr=%h data=%h, required no beat", mem_src_o, mem_addr_o, mem_data_o);
        end else begin
          if (sb_q[mon_idx].req.addr !== mem_addr_o || sb_q[mon_idx].req.data !== mem_data_o) begin
            bad++;
            $display("FAIL sb_order: src=%0d got addr=%h data=%h, required addr=%h data=%h",
                     mem_src_o, mem_addr_o, mem_data_o, sb_q[mon_idx].req.addr, sb_q[mon_idx].req.data);
          end
          sb_q.delete(mon_idx);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid_i[i] && req_ready_o[i]) begin
          mon_e.src      = 2'(i);
          mon_e.req.addr = req_addr_i[i];
          mon_e.req.data = req_data_i[i];
          sb_q.push_back(mon_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i     = 1'b1;
    req_valid_i = '0;
    tick();
    tick();
    sb_q.delete();
    reset_i = 1'b0;
  endtask

  // Waits (bounded) for the block to go idle; ok=0 if it never does.
  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_i);
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    mem_ready_i = 1'b1;
    req_addr_i  = '0;
    req_data_i  = '0;
    do_reset();
    @(negedge clk_i);
    total++;
    if ({mem_src_o, mem_addr_o, mem_data_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: src=%0d addr=%h data=%h, required all 0", mem_src_o, mem_addr_o, mem_data_o);
    end
    for (int c = 0; c < 20; c++) begin
      total++;
      if ({mem_valid_o, busy_o, req_ready_o} !== 6'b00_1111) begin
        bad++;
        $display("FAIL reset_idle cyc%0d: valid=%b busy=%b ready=%b, required 0 0 1111", c, mem_valid_o, busy_o, req_ready_o);
      end
      tick();
      @(negedge clk_i);
    end
  endtask

  task automatic test_single();
    bit ok;
    tick();
    mem_ready_i    = 1'b1;
    req_valid_i    = 4'b0100;
    req_addr_i[2]  = 16'h0040;
    req_data_i[2]  = 32'hDEADBEEF;
    tick();
    req_valid_i = '0;
    @(negedge clk_i);
    total++;
    if ({mem_valid_o, busy_o} !== 2'b01) begin
      bad++;
      $display("FAIL single_no_bypass: valid=%b busy=%b, required 0 1", mem_valid_o, busy_o);
    end
    tick();
    @(negedge clk_i);
    total++;
    if ({mem_valid_o, mem_src_o, mem_addr_o, mem_data_o} !== {1'b1, 2'd2, 16'h0040, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL single_beat: valid=%b src=%0d addr=%h data=%h, required 1 2 0040 deadbeef",
               mem_valid_o, mem_src_o, mem_addr_o, mem_data_o);
    end
    tick();
    @(negedge clk_i);
    total++;
    if ({mem_valid_o, busy_o} !== 2'b00) begin
      bad++;
      $display("FAIL single_one_cycle: valid=%b busy=%b, required 0 0", mem_valid_o, busy_o);
    end
    wait_idle(ok);
    total++;
    if (!ok || sb_q.size() != 0) begin
      bad++;
      $display("FAIL single_drain: idle=%b left=%0d, required 1 0", ok, sb_q.size());
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    mem_ready_i = 1'b1;
    do_reset();
    for (int b = 0; b < 2; b++) begin
      req_valid_i = 4'b1111;
      for (int c = 0; c < N; c++) begin
        req_addr_i[c] = 16'h1000 + 16'(c * 16 + b);
        req_data_i[c] = $urandom;
      end
      tick();
    end
    req_valid_i = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      total++;
      if ({mem_valid_o, mem_src_o} !== {1'b1, 2'(k % 4)}) begin
        bad++;
        $display("FAIL rr_seq beat%0d: valid=%b src=%0d, required 1 %0d", k, mem_valid_o, mem_src_o, k % 4);
      end
      tick();
    end
    @(negedge clk_i);
    total++;
    if (mem_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rr_end: valid=%b, required 0", mem_valid_o);
    end
    wait_idle(ok);
    total++;
    if (!ok || sb_q.size() != 0) begin
      bad++;
      $display("FAIL rr_drain: idle=%b left=%0d, required 1 0", ok, sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a [3];
    logic [DW-1:0] d [3];
    tick();
    mem_ready_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      a[b] = 16'h2000 + 16'(b);
      d[b] = 32'hA0A0_0000 + 32'(b * 7);
      req_valid_i   = 4'b0010;
      req_addr_i[1] = a[b];
      req_data_i[1] = d[b];
      tick();
    end
    req_valid_i = '0;
    @(negedge clk_i);
    total++;
    if (req_ready_o[1] !== 1'b0) begin
      bad++;
      $display("FAIL bp_ready: ready1=%b, required 0", req_ready_o[1]);
    end
    for (int s = 0; s < 3; s++) begin
      total++;
      if ({mem_valid_o, mem_src_o, mem_addr_o, mem_data_o} !== {1'b1, 2'd1, a[0], d[0]}) begin
        bad++;
        $display("FAIL bp_stall%0d: valid=%b src=%0d addr=%h data=%h, required 1 1 %h %h",
                 s, mem_valid_o, mem_src_o, mem_addr_o, mem_data_o, a[0], d[0]);
      end
      tick();
      @(negedge clk_i);
    end
    tick();
    mem_ready_i = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk_i);
      total++;
      if ({mem_valid_o, mem_addr_o, mem_data_o} !== {1'b1, a[b], d[b]}) begin
        bad++;
        $display("FAIL bp_drain%0d: valid=%b addr=%h data=%h, required 1 %h %h",
                 b, mem_valid_o, mem_addr_o, mem_data_o, a[b], d[b]);
      end
      tick();
    end
    @(negedge clk_i);
    total++;
    if (mem_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL bp_end: valid=%b, required 0", mem_valid_o);
    end
  endtask

  task automatic test_full_pop();
    bit ok;
    tick();
    mem_ready_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      req_valid_i   = 4'b0001;
      req_addr_i[0] = 16'h3000 + 16'(b);
      req_data_i[0] = $urandom;
      tick();
    end
    req_addr_i[0] = 16'h3003;
    req_data_i[0] = 32'h5A5A_0003;
    mem_ready_i   = 1'b1;
    @(negedge clk_i);
    total++;
    if ({mem_valid_o, req_ready_o[0]} !== 2'b10) begin
      bad++;
      $display("FAIL full_pop_same: valid=%b ready0=%b, required 1 0", mem_valid_o, req_ready_o[0]);
    end
    tick();
    @(negedge clk_i);
    total++;
    if (req_ready_o[0] !== 1'b1) begin
      bad++;
      $display("FAIL full_pop_next: ready0=%b, required 1", req_ready_o[0]);
    end
    tick();
    req_valid_i = '0;
    wait_idle(ok);
    total++;
    if (!ok || sb_q.size() != 0) begin
      bad++;
      $display("FAIL full_pop_drain: idle=%b left=%0d, required 1 0", ok, sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    tick();
    mem_ready_i = 1'b0;
    req_valid_i = 4'b1111;
    for (int c = 0; c < N; c++) begin
      req_addr_i[c] = 16'h4000 + 16'(c);
      req_data_i[c] = $urandom;
    end
    tick();
    req_valid_i = 4'b0011;
    for (int c = 0; c < 2; c++) begin
      req_addr_i[c] = 16'h4100 + 16'(c);
      req_data_i[c] = $urandom;
    end
    tick();
    req_valid_i = '0;
    @(negedge clk_i);
    total++;
    if ({mem_valid_o, busy_o} !== 2'b11) begin
      bad++;
      $display("FAIL rst_mid_pre: valid=%b busy=%b, required 1 1", mem_valid_o, busy_o);
    end
    tick();
    reset_i     = 1'b1;
    mem_ready_i = 1'b1;
    sb_q.delete();
    tick();
    reset_i = 1'b0;
    @(negedge clk_i);
    total++;
    if ({mem_valid_o, busy_o, req_ready_o} !== 6'b00_1111) begin
      bad++;
      $display("FAIL rst_mid_post: valid=%b busy=%b ready=%b, required 0 0 1111", mem_valid_o, busy_o, req_ready_o);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge clk_i);
      total++;
      if (mem_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL rst_mid_ghost cyc%0d: valid=%b src=%0d addr=%h, required valid 0", c, mem_valid_o, mem_src_o, mem_addr_o);
      end
    end
  endtask

  initial begin
    reset_i     = 1'b1;
    req_valid_i = '0;
    req_addr_i  = '0;
    req_data_i  = '0;
    mem_ready_i = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_write_arb.md
Name: alu_write_arb

Overview:
- Shares one data-memory write port between `num_cores` ALU cores.
- Each core's write request (address + data) is captured into a small per-core FIFO.
- A round-robin scheduler drains the FIFOs into a single registered valid/ready memory port, tagging each beat with its source core.
- Sits between the ALU cores' memory-write outputs and the shared data-memory write interface.

Parameters:
- num_cores, 4, number of requesting cores; 2..16.
- mem_addr_width, 16, width of a memory address.
- fifo_depth, 2, entries per core FIFO; power of two, >= 2.
- src_width, $clog2(num_cores), width of the source-core tag (derived, not overridable).

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  num_cores  per-core write request valid.
- req_addr_i  in  num_cores x mem_addr_width  per-core write address.
- req_data_i  in  num_cores x `REG_WIDTH  per-core write data.
- req_ready_o  out  num_cores  per-core accept; a request is taken when valid & ready at a rising edge.
- mem_valid_o  out  1  memory write beat valid.
- mem_addr_o  out  mem_addr_width  memory write address.
- mem_data_o  out  `REG_WIDTH  memory write data.
- mem_src_o  out  src_width  index of the core that issued the beat.
- mem_ready_i  in  1  memory accepts the beat when mem_valid_o & mem_ready_i.
- busy_o  out  1  high while any FIFO is non-empty or mem_valid_o is high.

Behaviour:
- Reset (synchronous, active-high):
  - All FIFOs empty.
  - mem_valid_o=0; mem_addr_o, mem_data_o and mem_src_o = 0.
  - RR pointer last_grant = num_cores-1, so core 0 has first priority.
  - busy_o=0.
  - Reset mid-transfer discards all queued and in-flight beats; no beat is emitted in the cycle after reset.
- req_ready_o[i] = (count[i] != fifo_depth).
  - Driven only by registered count; it does not see a same-cycle pop.
  - A full FIFO stays not-ready for one cycle even if it is popped that cycle.
- Push: on an edge with req_valid_i[i] & req_ready_o[i], {addr,data} is written to FIFO i.
  - Simultaneous push and pop on the same FIFO: count unchanged, data ordering preserved.
- Output register update condition: load_en = !mem_valid_o | mem_ready_i.
- When load_en is high:
  - Candidates are the FIFOs non-empty at the start of the cycle.
  - Grant g is the first candidate scanning last_grant+1, last_grant+2, … modulo num_cores.
  - FIFO g is popped. mem_valid_o<=1, addr/data <= head of g, mem_src_o<=g, last_grant<=g.
  - If there is no candidate: mem_valid_o<=0, addr/data/src hold, last_grant holds.
- When load_en is low (beat stalled): mem_valid_o, mem_addr_o, mem_data_o and mem_src_o are stable; no pop.
- Latency: request accepted at edge E0 -> mem_valid_o high after edge E1 (2 cycles valid-to-valid), provided the port is free.
  - A request arriving at an empty FIFO is never bypassed to the port.
- Throughput: one beat per cycle while mem_ready_i=1 and any FIFO is non-empty.
- Fairness: with all cores continuously backlogged, grants are strictly 0,1,2,…,num_cores-1,0,…
  - A core waits at most num_cores-1 beats once its FIFO is non-empty.
- Per-core ordering: beats from one core leave in acceptance order; no ordering between cores is guaranteed.
- FIFO pointers wrap modulo fifo_depth; count is log2(fifo_depth)+1 bits.
- busy_o = mem_valid_o | any count != 0 (combinational from registers).
- Assertions:
  - No push to a full FIFO.
  - No pop from an empty FIFO.
  - mem_* stable while mem_valid_o & !mem_ready_i.

Decomposition:
- Shared package:
  - mem_write_req_s packed struct {addr[mem_addr_width], data[`REG_WIDTH]}.
  - `REG_WIDTH is reused from the existing ALU definitions.
- Sub-module alu_write_fifo:
  - Parameters: depth, width.
  - Ports: push/pop, data in/out, count, full/empty.
  - Synchronous reset.
  - Instantiated num_cores times via generate.
- RR selection is a combinational function inside alu_write_arb (double-width priority scan).

Test Plan:
- Reset then idle: all req_valid_i=0 -> mem_valid_o=0, busy_o=0, req_ready_o=4'b1111 for 20 cycles.
- Single request: core 2 sends addr=16'h0040, data=32'hDEADBEEF at E0, mem_ready_i=1 -> mem_valid_o high after E1 for exactly 1 cycle with that addr/data and mem_src_o=2.
- Round robin: all 4 cores each push 2 beats in the same cycle, mem_ready_i=1 -> mem_src_o sequence 0,1,2,3,0,1,2,3 on consecutive cycles; per-core data order preserved.
- Backpressure: core 1 pushes 3 beats with mem_ready_i=0 ->
  - beat A is loaded to the port; FIFO holds B,C, so req_ready_o[1]=0;
  - mem_* stable while stalled;
  - raising mem_ready_i drains A,B,C in order on 3 consecutive cycles.
- Full FIFO + same-cycle pop: FIFO 0 full, mem_ready_i=1 -> req_ready_o[0]=0 that cycle; it rises the next cycle; no beat lost or duplicated (scoreboard).
- Reset mid-operation: assert reset_i while mem_valid_o=1 and FIFOs hold 5 beats -> next cycle mem_valid_o=0, busy_o=0, and no old beat ever reappears.
